mcp3202_sched: RTL and testbench
================================

Name: mcp3202_sched

Overview:
- Round-robin scheduler that shares one MCP3202 SPI conversion engine between two requesters.
- Each requester asks for one conversion with its own SGL/ODD (mode/channel) setting.
- Issues a one-shot start command to the engine, waits for completion, and returns the 12-bit result to the granted requester.
- Enforces a minimum idle (CS-high) gap between back-to-back conversions.

Parameters:
- GAP_CYCLES, 68: idle cycles inserted after each result before the next grant. 0 means no gap.
- TIMEOUT_CYCLES, 4096: WAIT-state watchdog limit in clk cycles. Used only with the optional feature.

Ports:
- clk  in  1  system clock (125 MHz)
- rst  in  1  asynchronous, active-high reset
- req_valid  in  2  per-requester conversion request; held high until req_ready
- req_sgl  in  2  per-requester SGL bit (1 = single-ended)
- req_odd  in  2  per-requester ODD bit (channel select)
- req_ready  out  2  one-cycle accept pulse, one-hot, to the granted requester
- res_valid  out  2  one-cycle result pulse, one-hot, to the granted requester
- res_data  out  12  result word; valid while res_valid is high, held afterwards
- eng_start  out  1  one-cycle start pulse to the SPI engine
- eng_sgl  out  1  latched SGL for the engine, stable from GRANT through WAIT
- eng_odd  out  1  latched ODD for the engine, stable from GRANT through WAIT
- eng_busy  in  1  engine busy; eng_start is never issued while this is high
- eng_done  in  1  engine one-cycle completion pulse
- eng_data  in  12  engine result, valid with eng_done
- sched_busy  out  1  high in every state except IDLE
- err_timeout  out  1  sticky watchdog error flag

Behaviour:
- Reset (async, any time, including mid-conversion):
  - state = IDLE.
  - All outputs 0, res_data = 0.
  - last_grant = 1, so requester 0 wins first.
  - Gap and timeout counters = 0.
- States: IDLE, GRANT, START, WAIT, DONE, GAP.
- IDLE:
  - No req_valid: stay in IDLE.
  - Exactly one req_valid: grant that requester.
  - Both req_valid: grant the requester that is not last_grant.
  - On leaving IDLE: latch g, eng_sgl = req_sgl[g], eng_odd = req_odd[g], last_grant = g. Go to GRANT.
- GRANT: req_ready[g] = 1 for exactly one cycle, then go to START.
- START:
  - eng_busy = 1: hold in START with eng_start = 0.
  - eng_busy = 0: eng_start = 1 for one cycle, then go to WAIT.
- WAIT: on eng_done, res_data <= eng_data and go to DONE.
- DONE: res_valid[g] = 1 for one cycle.
  - GAP_CYCLES > 0: go to GAP.
  - GAP_CYCLES = 0: go to IDLE.
- GAP: count GAP_CYCLES cycles (counter 0 .. GAP_CYCLES-1), then go to IDLE. Requests are not sampled in GAP.
- Latency:
  - req_valid seen in IDLE at cycle N: req_ready at N+1, eng_start at N+2 (if engine idle).
  - eng_done at M: res_valid at M+1.
  - Earliest next req_ready: M+GAP_CYCLES+3.
- Boundary rules:
  - eng_done outside WAIT is ignored.
  - Requests are sampled only in IDLE. A req_valid dropped before grant is simply not served.
  - A requester that re-asserts req_valid immediately loses to the other requester if both are pending (strict alternation under contention).
  - eng_sgl and eng_odd change only on the IDLE→GRANT transition.
  - res_data holds its last value until the next DONE.

Optional Feature:
- Macro: MCP3202_SCHED_TIMEOUT_EN.
- Defined:
  - WAIT counts cycles. The counter clears on entry to WAIT.
  - If TIMEOUT_CYCLES elapse without eng_done: err_timeout <= 1 (sticky, cleared only by rst), res_data <= 12'hFFF, go to DONE (res_valid[g] still pulses), then GAP as normal.
  - eng_done on the same cycle as the expiry wins: normal data is returned and no error is flagged.
- Not defined:
  - WAIT waits indefinitely.
  - err_timeout is tied to 0.
  - No counter logic is instantiated.

Test Plan:
- Single request: req_valid=2'b01, req_sgl[0]=1, req_odd[0]=0; engine returns 12'hA5C, 20 cycles after eng_start → req_ready=01 one cycle after the request, eng_start one cycle after that, eng_sgl=1, eng_odd=0, res_valid=01 with res_data=12'hA5C one cycle after eng_done.
- Contention: both req_valid held high for 4 conversions, GAP_CYCLES=68 → grants go 0,1,0,1. Each eng_start is at least 68+3 cycles after the previous eng_done, and the correct res_valid bit pulses each time.
- Busy engine: eng_busy=1 for 50 cycles after GRANT → eng_start stays 0 throughout, then pulses on the first cycle eng_busy=0.
- Async reset mid-WAIT: rst pulsed while in WAIT → all outputs 0 immediately. A stray eng_done after reset produces no res_valid. The next request from requester 0 is served normally.
- Spurious done: eng_done pulsed while in IDLE and while in GAP → no res_valid, and res_data is unchanged.
- Timeout (with MCP3202_SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=100): engine never asserts done → after 100 WAIT cycles, res_valid pulses with res_data=12'hFFF and err_timeout goes to 1 and stays at 1 until rst.

Source files
------------

// File: rtl/mcp3202_sched.sv
// -----------------------------------------------------------------------------
// mcp3202_sched
//
// Round-robin scheduler that shares one MCP3202 SPI conversion engine between
// two requesters. A requester posts a request with its own SGL/ODD setting.
// The scheduler grants one requester and fires a one-shot start at the engine.
// It then waits for the engine's done pulse and hands the 12-bit result back
// to the granted requester. Before the next grant it holds a fixed idle gap,
// during which the converter's chip select stays high.
//
// Parameters:
//   GAP_CYCLES      idle cycles after each result before the next grant (0 = none)
//   TIMEOUT_CYCLES  WAIT-state watchdog limit (only with MCP3202_SCHED_TIMEOUT_EN)
//
// Optional feature macro: MCP3202_SCHED_TIMEOUT_EN
//   defined   : WAIT is guarded by a watchdog. On expiry it returns 12'hFFF and
//               sets the sticky err_timeout_o.
//   undefined : WAIT waits indefinitely and err_timeout_o is tied low.
//
// Ports:
//   clk_i          system clock
//   rst_i          asynchronous, active-high reset
//   req_valid_i    per-requester conversion request, held until req_ready_o
//   req_sgl_i      per-requester SGL bit (1 = single-ended)
//   req_odd_i      per-requester ODD bit (channel select)
//   req_ready_o    one-cycle one-hot accept pulse to the granted requester
//   res_valid_o    one-cycle one-hot result pulse to the granted requester
//   res_data_o     result word, held until the next result
//   eng_start_o    one-cycle start pulse to the SPI engine
//   eng_sgl_o      latched SGL for the engine
//   eng_odd_o      latched ODD for the engine
//   eng_busy_i     engine busy, blocks eng_start_o
//   eng_done_i     engine one-cycle completion pulse
//   eng_data_i     engine result, valid with eng_done_i
//   sched_busy_o   high in every state except IDLE
//   err_timeout_o  sticky watchdog error flag
// -----------------------------------------------------------------------------
module mcp3202_sched #(
  parameter int GAP_CYCLES     = 68,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  req_valid_i,
  input  logic [1:0]  req_sgl_i,
  input  logic [1:0]  req_odd_i,
  output logic [1:0]  req_ready_o,
  output logic [1:0]  res_valid_o,
  output logic [11:0] res_data_o,
  output logic        eng_start_o,
  output logic        eng_sgl_o,
  output logic        eng_odd_o,
  input  logic        eng_busy_i,
  input  logic        eng_done_i,
  input  logic [11:0] eng_data_i,
  output logic        sched_busy_o,
  output logic        err_timeout_o
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_GRANT = 3'd1;
  localparam logic [2:0] ST_START = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;
  localparam logic [2:0] ST_GAP   = 3'd5;

  // The gap phase and the WAIT watchdog never overlap, so one counter serves
  // both. It is sized for the larger of the two terminal counts.
  localparam int CNT_MAX = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
`ifdef MCP3202_SCHED_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
`endif

  logic [2:0]       state_q, state_d;
  logic             grant_q, grant_d;     // granted requester; doubles as last_grant
  logic             sgl_q, sgl_d;
  logic             odd_q, odd_d;
  logic [11:0]      res_data_q, res_data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef MCP3202_SCHED_TIMEOUT_EN
  logic             err_q, err_d;
`endif

  logic             pick;
  logic [1:0]       grant_oh;

  // Under contention the requester that did not win last time is picked.
  // A lone request is granted regardless of history.
  always_comb begin
    if (req_valid_i == 2'b11) pick = ~grant_q;
    else                      pick = req_valid_i[1];
  end

  assign grant_oh = grant_q ? 2'b10 : 2'b01;

  always_comb begin
    // NOTE: every next-state variable gets its hold value first, so no path
    // through the case statement leaves one unassigned and infers a latch.
    state_d    = state_q;
    grant_d    = grant_q;
    sgl_d      = sgl_q;
    odd_d      = odd_q;
    res_data_d = res_data_q;
    cnt_d      = cnt_q;
`ifdef MCP3202_SCHED_TIMEOUT_EN
    err_d      = err_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (|req_valid_i) begin
          grant_d = pick;
          sgl_d   = req_sgl_i[pick];
          odd_d   = req_odd_i[pick];
          state_d = ST_GRANT;
        end
      end

      ST_GRANT: state_d = ST_START;

      ST_START: begin
        if (!eng_busy_i) begin
          state_d = ST_WAIT;
`ifdef MCP3202_SCHED_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end

      ST_WAIT: begin
        // A done pulse on the same cycle as the watchdog expiry takes
        // priority. Real data beats the error path.
        if (eng_done_i) begin
          res_data_d = eng_data_i;
          state_d    = ST_DONE;
        end
`ifdef MCP3202_SCHED_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          res_data_d = 12'hFFF;
          err_d      = 1'b1;
          state_d    = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end

      ST_DONE: begin
        cnt_d   = '0;
        state_d = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
      end

      ST_GAP: begin
        if (cnt_q == GAP_LAST) state_d = ST_IDLE;
        else                   cnt_d   = cnt_q + 1'b1;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      grant_q    <= 1'b1;           // requester 0 wins the first contention
      sgl_q      <= 1'b0;
      odd_q      <= 1'b0;
      res_data_q <= '0;
      cnt_q      <= '0;
`ifdef MCP3202_SCHED_TIMEOUT_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      sgl_q      <= sgl_d;
      odd_q      <= odd_d;
      res_data_q <= res_data_d;
      cnt_q      <= cnt_d;
`ifdef MCP3202_SCHED_TIMEOUT_EN
      err_q      <= err_d;
`endif
    end
  end

  // Handshake outputs decode directly from the state register. They therefore
  // fall to zero the moment reset asserts, even in the middle of a cycle.
  assign req_ready_o  = (state_q == ST_GRANT) ? grant_oh : 2'b00;
  assign res_valid_o  = (state_q == ST_DONE)  ? grant_oh : 2'b00;
  assign eng_start_o  = (state_q == ST_START) && !eng_busy_i;
  assign sched_busy_o = (state_q != ST_IDLE);
  assign eng_sgl_o    = sgl_q;
  assign eng_odd_o    = odd_q;
  assign res_data_o   = res_data_q;

`ifdef MCP3202_SCHED_TIMEOUT_EN
  assign err_timeout_o = err_q;
`else
  assign err_timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_mcp3202_sched.sv
// -----------------------------------------------------------------------------
// tb_mcp3202_sched
//
// Directed testbench for mcp3202_sched. The bench acts as both requesters and
// as the SPI engine, and it drives eng_done/eng_data by hand. Inputs change and
// outputs are sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_mcp3202_sched;

  localparam int GAP = 68;
`ifdef MCP3202_SCHED_TIMEOUT_EN
  localparam int TO = 100;
`else
  localparam int TO = 4096;
`endif

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_sgl;
  logic [1:0]  req_odd;
  logic [1:0]  req_ready;
  logic [1:0]  res_valid;
  logic [11:0] res_data;
  logic        eng_start;
  logic        eng_sgl;
  logic        eng_odd;
  logic        eng_busy;
  logic        eng_done;
  logic [11:0] eng_data;
  logic        sched_busy;
  logic        err_timeout;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  mcp3202_sched #(
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .req_valid_i   (req_valid),
    .req_sgl_i     (req_sgl),
    .req_odd_i     (req_odd),
    .req_ready_o   (req_ready),
    .res_valid_o   (res_valid),
    .res_data_o    (res_data),
    .eng_start_o   (eng_start),
    .eng_sgl_o     (eng_sgl),
    .eng_odd_o     (eng_odd),
    .eng_busy_i    (eng_busy),
    .eng_done_i    (eng_done),
    .eng_data_i    (eng_data),
    .sched_busy_o  (sched_busy),
    .err_timeout_o (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Advance until a grant pulse appears (bounded), then check which one.
  task automatic wait_ready(input string tag, input logic [1:0] exp, output int at);
    int n;
    n = 0;
    while (req_ready === 2'b00 && n < 200) begin
      tick;
      n++;
    end
    check(tag, req_ready, exp);
    at = cyc;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (sched_busy !== 1'b0 && n < 200) begin
      tick;
      n++;
    end
    check(tag, sched_busy, 1'b0);
  endtask

  // One-cycle engine completion pulse; leaves the bench on the DONE cycle.
  task automatic pulse_done(input logic [11:0] data);
    eng_done = 1'b1;
    eng_data = data;
    tick;
    eng_done = 1'b0;
  endtask

  initial begin
    int t_ready, t_start, t_done, busy_bad;
    logic [1:0] exp_g;

    rst = 1'b1; req_valid = '0; req_sgl = '0; req_odd = '0;
    eng_busy = 1'b0; eng_done = 1'b0; eng_data = '0;

    // ---------------- reset state ----------------
    #12;
    check("rst_busy",  sched_busy, 1'b0);
    check("rst_ready", req_ready, 2'b00);
    check("rst_res",   res_data, 12'h000);
    check("rst_start", eng_start, 1'b0);
    tick;
    rst = 1'b0;
    cyc = 0;

    // ---------------- single request ----------------
    req_valid = 2'b01; req_sgl = 2'b01; req_odd = 2'b10;
    check("single_idle_ready", req_ready, 2'b00);
    tick;                                           // GRANT
    check("single_ready", req_ready, 2'b01);
    check("single_sgl",   eng_sgl, 1'b1);
    check("single_odd",   eng_odd, 1'b0);
    check("single_nostart", eng_start, 1'b0);
    req_valid = 2'b00;
    tick;                                           // START, engine idle
    check("single_start", eng_start, 1'b1);
    t_start = cyc;
    tick;                                           // WAIT
    check("single_start_once", eng_start, 1'b0);
    repeat (19) tick;
    check("single_wait_nores", res_valid, 2'b00);
    pulse_done(12'hA5C);                            // done at start+20
    check("single_done_lat", cyc - t_start, 21);
    check("single_res_valid", res_valid, 2'b01);
    check("single_res_data",  res_data, 12'hA5C);
    tick;                                           // GAP
    check("single_res_pulse", res_valid, 2'b00);
    check("single_res_hold",  res_data, 12'hA5C);

    // ---------------- spurious done in GAP and IDLE ----------------
    pulse_done(12'h123);
    check("spur_gap_valid", res_valid, 2'b00);
    check("spur_gap_data",  res_data, 12'hA5C);
    wait_idle("spur_reach_idle");
    pulse_done(12'h456);
    check("spur_idle_valid", res_valid, 2'b00);
    check("spur_idle_data",  res_data, 12'hA5C);
    check("spur_idle_busy",  sched_busy, 1'b0);

    // ---------------- contention ----------------
    // Requester 0 was served last, so alternation starts at requester 1.
    req_valid = 2'b11; req_sgl = 2'b10; req_odd = 2'b01;
    t_done = 0;
    for (int i = 0; i < 4; i++) begin
      exp_g = (i % 2 == 0) ? 2'b10 : 2'b01;
      wait_ready($sformatf("cont%0d_grant", i), exp_g, t_ready);
      if (i > 0) check($sformatf("cont%0d_gap", i), t_ready - t_done, GAP + 3);
      check($sformatf("cont%0d_sgl", i), eng_sgl, (i % 2 == 0));
      check($sformatf("cont%0d_odd", i), eng_odd, (i % 2 != 0));
      tick;                                         // START
      check($sformatf("cont%0d_start", i), eng_start, 1'b1);
      t_start = cyc;
      if (i > 0) check($sformatf("cont%0d_start_gap", i), (t_start - t_done) >= GAP + 3, 1'b1);
      tick;                                         // WAIT
      repeat (5 + i) tick;
      t_done = cyc;
      pulse_done(12'h100 + 12'(i));
      check($sformatf("cont%0d_res_valid", i), res_valid, exp_g);
      check($sformatf("cont%0d_res_data", i),  res_data, 12'h100 + 12'(i));
    end
    req_valid = 2'b00;
    wait_idle("cont_idle");

    // ---------------- busy engine ----------------
    req_valid = 2'b10; req_sgl = 2'b10; req_odd = 2'b10;
    wait_ready("busy_grant", 2'b10, t_ready);
    req_valid = 2'b00;
    eng_busy  = 1'b1;
    busy_bad  = 0;
    repeat (50) begin
      tick;
      if (eng_start !== 1'b0) busy_bad++;
    end
    check("busy_hold_start", busy_bad, 0);
    check("busy_still_busy", sched_busy, 1'b1);
    eng_busy = 1'b0;
    #1;
    check("busy_release_start", eng_start, 1'b1);
    tick;                                           // WAIT
    check("busy_start_once", eng_start, 1'b0);
    repeat (3) tick;
    pulse_done(12'h3C3);
    check("busy_res_valid", res_valid, 2'b10);
    check("busy_res_data",  res_data, 12'h3C3);
    wait_idle("busy_idle");

    // ---------------- async reset mid-WAIT ----------------
    req_valid = 2'b01; req_sgl = 2'b00; req_odd = 2'b01;
    wait_ready("arst_grant", 2'b01, t_ready);
    req_valid = 2'b00;
    tick;                                           // START
    tick;                                           // WAIT
    repeat (3) tick;
    check("arst_pre_odd", eng_odd, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("arst_busy",  sched_busy, 1'b0);
    check("arst_odd",   eng_odd, 1'b0);
    check("arst_data",  res_data, 12'h000);
    check("arst_ready", req_ready, 2'b00);
    check("arst_valid", res_valid, 2'b00);
    tick;
    rst = 1'b0;
    pulse_done(12'h777);
    check("arst_stray_valid", res_valid, 2'b00);
    check("arst_stray_data",  res_data, 12'h000);
    // Both pending: reset restores last_grant = 1, so requester 0 wins again.
    req_valid = 2'b11; req_sgl = 2'b01; req_odd = 2'b00;
    wait_ready("arst_regrant", 2'b01, t_ready);
    check("arst_regrant_sgl", eng_sgl, 1'b1);
    req_valid = 2'b00;
    tick;
    check("arst_restart", eng_start, 1'b1);
    tick;
    repeat (2) tick;
    pulse_done(12'h0F0);
    check("arst_res_valid", res_valid, 2'b01);
    check("arst_res_data",  res_data, 12'h0F0);
    wait_idle("arst_idle");

`ifdef MCP3202_SCHED_TIMEOUT_EN
    // ---------------- done on the expiry cycle wins ----------------
    req_valid = 2'b01;
    wait_ready("to_race_grant", 2'b01, t_ready);
    req_valid = 2'b00;
    tick;                                           // START
    tick;                                           // first WAIT cycle
    repeat (TO - 1) tick;                           // last WAIT cycle
    pulse_done(12'h234);
    check("to_race_valid", res_valid, 2'b01);
    check("to_race_data",  res_data, 12'h234);
    check("to_race_err",   err_timeout, 1'b0);
    wait_idle("to_race_idle");

    // ---------------- watchdog expiry ----------------
    req_valid = 2'b01;
    wait_ready("to_grant", 2'b01, t_ready);
    req_valid = 2'b00;
    tick;
    tick;                                           // first WAIT cycle
    repeat (TO - 1) tick;
    check("to_pre_valid", res_valid, 2'b00);
    check("to_pre_err",   err_timeout, 1'b0);
    tick;                                           // DONE by timeout
    check("to_valid", res_valid, 2'b01);
    check("to_data",  res_data, 12'hFFF);
    check("to_err",   err_timeout, 1'b1);
    wait_idle("to_idle");
    check("to_err_sticky", err_timeout, 1'b1);
    rst = 1'b1;
    #1;
    check("to_err_cleared", err_timeout, 1'b0);
    tick;
    rst = 1'b0;
`else
    check("no_to_err", err_timeout, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
    $fatal(1);
  end

endmodule
